// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider. A single combinational subtractor
// is reused once per clock. Each pass produces one quotient bit, so a
// full-width divide takes WIDTH iterations.

// Combinational subtractor. Borrow is set when A < B, which means the trial
// subtraction failed.
module restoring_divider_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_difference,
    output logic             o_borrow
);
    assign {o_borrow, o_difference} = {1'b0, i_a} - {1'b0, i_b};
endmodule

module restoring_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ITERS    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic             w_msb;
    logic [WIDTH-1:0] w_rs;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;
    logic             w_accept;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    // Shift the partial remainder left and bring in the next dividend bit.
    // The bit shifted out of R is the 33rd bit of the trial value. It only
    // matters when the divisor has its top bit set.
    assign w_msb = r_rem[WIDTH-1];
    assign w_rs  = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};

    restoring_divider_sub #(.WIDTH(WIDTH)) u_sub (
        .i_a          (w_rs),
        .i_b          (r_d),
        .o_difference (w_diff),
        .o_borrow     (w_borrow)
    );

    // If the 33-bit trial value is at least D, keep the difference.
    // Otherwise restore the value to the shifted remainder.
    assign w_accept   = w_msb | ~w_borrow;
    assign w_rem_next = w_accept ? w_diff : w_rs;
    assign w_q_next   = {r_q[WIDTH-2:0], w_accept};

    // Control FSM with the iteration datapath and the registered result outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_divisor != '0) begin
                            r_d        <= i_divisor;
                            r_q        <= i_dividend;
                            r_rem      <= '0;
                            r_count    <= ITERS;
                            r_div_zero <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_RUN;
                        end else begin
                            // Divide by zero skips the iterations.
                            // Report the conventional all-ones quotient.
                            r_quotient  <= '1;
                            r_remainder <= i_dividend;
                            r_div_zero  <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    r_rem   <= w_rem_next;
                    r_q     <= w_q_next;
                    r_count <= r_count - LAST_CNT;
                    if (r_count == LAST_CNT) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_div_zero  = r_div_zero;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed testbench for restoring_divider. Each scenario task drives its own
// stimulus and checks its results against hand-computed values.
module tb_restoring_divider;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    restoring_divider dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .o_quotient (quotient),
        .o_remainder(remainder),
        .o_busy     (busy),
        .o_done     (done),
        .o_div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op, scramble the operand inputs, then wait (bounded) for done.
    // The returned count is the number of cycles after the start edge.
    // When the task returns, the current cycle is the done cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int cycles);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hA5A5_5A5A;
        divisor  = 32'h0000_0003;
        cycles   = 1;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL reset_quotient got=%h want=0", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL reset_remainder got=%h want=0", remainder); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b want=0", div_zero); end
        $display("reset: q=%h r=%h busy=%b done=%b dz=%b", quotient, remainder, busy, done, div_zero);
    endtask

    task automatic test_basic;
        int cyc;
        run_op(32'd7, 32'd3, cyc);
        $display("7/3: cycles=%0d q=%0d r=%0d dz=%b", cyc, quotient, remainder, div_zero);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL basic_latency got=%0d want=33", cyc); end
        checks++; if (quotient !== 32'd2) begin failures++; $display("FAIL basic_quotient got=%0d want=2", quotient); end
        checks++; if (remainder !== 32'd1) begin failures++; $display("FAIL basic_remainder got=%0d want=1", remainder); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL basic_div_zero got=%b want=0", div_zero); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        checks++; if (quotient !== 32'd2) begin failures++; $display("FAIL basic_hold got=%0d want=2", quotient); end
    endtask

    task automatic test_small_over_large;
        int cyc;
        run_op(32'd5, 32'd9, cyc);
        $display("5/9: cycles=%0d q=%0d r=%0d", cyc, quotient, remainder);
        checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL borrow_quotient got=%0d want=0", quotient); end
        checks++; if (remainder !== 32'd5) begin failures++; $display("FAIL borrow_remainder got=%0d want=5", remainder); end
    endtask

    task automatic test_msb;
        int cyc;
        run_op(32'hFFFF_FFFF, 32'h8000_0000, cyc);
        $display("FFFFFFFF/80000000: cycles=%0d q=%h r=%h", cyc, quotient, remainder);
        checks++; if (quotient !== 32'd1) begin failures++; $display("FAIL msb_quotient got=%h want=1", quotient); end
        checks++; if (remainder !== 32'h7FFF_FFFF) begin failures++; $display("FAIL msb_remainder got=%h want=7fffffff", remainder); end
        run_op(32'hFFFF_FFFF, 32'd1, cyc);
        $display("FFFFFFFF/1: cycles=%0d q=%h r=%h", cyc, quotient, remainder);
        checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div1_quotient got=%h want=ffffffff", quotient); end
        checks++; if (remainder !== 32'd0) begin failures++; $display("FAIL div1_remainder got=%h want=0", remainder); end
    endtask

    task automatic test_div_zero;
        int cyc;
        run_op(32'd100, 32'd0, cyc);
        $display("100/0: cycles=%0d q=%h r=%0d dz=%b", cyc, quotient, remainder, div_zero);
        checks++; if (cyc !== 1) begin failures++; $display("FAIL dz_latency got=%0d want=1", cyc); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b want=1", div_zero); end
        checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_quotient got=%h want=ffffffff", quotient); end
        checks++; if (remainder !== 32'd100) begin failures++; $display("FAIL dz_remainder got=%0d want=100", remainder); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL dz_busy got=%b want=0", busy); end
    endtask

    // Runs 1000/7 after the divide-by-zero op. A stray start in RUN must be
    // ignored. Outputs must hold the previous result during RUN.
    task automatic test_ignore_start;
        int cyc;
        int busy_cnt;
        logic [31:0] q_mid;
        @(negedge clk);
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        q_mid    = '0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            if (cyc == 10) begin
                start    = 1'b1;
                dividend = 32'd20;
                divisor  = 32'd4;
            end else begin
                start = 1'b0;
            end
            if (cyc == 16) q_mid = quotient;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        $display("1000/7 w/ stray start: cycles=%0d busy=%0d q=%0d r=%0d mid_q=%h", cyc, busy_cnt, quotient, remainder, q_mid);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL ign_latency got=%0d want=33", cyc); end
        checks++; if (busy_cnt !== 32) begin failures++; $display("FAIL ign_busy_cycles got=%0d want=32", busy_cnt); end
        checks++; if (q_mid !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ign_hold_in_run got=%h want=ffffffff", q_mid); end
        checks++; if (quotient !== 32'd142) begin failures++; $display("FAIL ign_quotient got=%0d want=142", quotient); end
        checks++; if (remainder !== 32'd6) begin failures++; $display("FAIL ign_remainder got=%0d want=6", remainder); end
    endtask

    // Holds start high during the done cycle. The next op must not launch.
    task automatic test_back_to_back;
        int cyc;
        run_op(32'd50, 32'd6, cyc);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        $display("50/6 then start on done: q=%0d r=%0d busy=%b", quotient, remainder, busy);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_start_on_done got=%b want=0", busy); end
        checks++; if (quotient !== 32'd8) begin failures++; $display("FAIL b2b_quotient got=%0d want=8", quotient); end
        run_op(32'd9, 32'd2, cyc);
        $display("9/2: cycles=%0d q=%0d r=%0d", cyc, quotient, remainder);
        checks++; if (quotient !== 32'd4 || remainder !== 32'd1) begin failures++; $display("FAIL b2b_second got=%0d/%0d want=4/1", quotient, remainder); end
    endtask

    task automatic test_mid_reset;
        int cyc;
        @(negedge clk);
        dividend = 32'd7;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        $display("mid-run reset: q=%0d r=%0d busy=%b done=%b dz=%b", quotient, remainder, busy, done, div_zero);
        checks++; if (quotient !== 32'd0 || remainder !== 32'd0) begin failures++; $display("FAIL mid_reset_results got=%h/%h want=0/0", quotient, remainder); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got=%b%b%b want=000", busy, done, div_zero); end
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd7, 32'd3, cyc);
        $display("7/3 after reset: cycles=%0d q=%0d r=%0d", cyc, quotient, remainder);
        checks++; if (cyc !== 33) begin failures++; $display("FAIL post_reset_latency got=%0d want=33", cyc); end
        checks++; if (quotient !== 32'd2 || remainder !== 32'd1) begin failures++; $display("FAIL post_reset_result got=%0d/%0d want=2/1", quotient, remainder); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_over_large();
        test_msb();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
